// File: rtl/pipe_buf_stage.sv
// Pipeline buffer register between two core stages.
// Carries an opaque WIDTH-bit payload with valid/ready handshaking, an
// optional 2-entry skid buffer, synchronous flush that inserts a bubble,
// and saturating stall/flush performance counters.
module pipe_buf_stage #(
    parameter int unsigned             WIDTH      = 32,
    parameter int unsigned             SKID       = 1,
    parameter logic [WIDTH-1:0]        BUBBLE_VAL = '0,
    parameter int unsigned             CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [WIDTH-1:0]  main_q;
    logic [WIDTH-1:0]  skid_q;
    logic              valid_q;
    logic              ready_q;
    logic              in_xfer;
    logic              out_xfer;

    // Skid mode: in_ready is a flop (no path from out_ready).
    // Single-register mode: accept when empty or when the held entry leaves.
    assign in_ready  = (SKID != 0) ? ready_q : (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;

    // Buffer state machine; main_q is forced to BUBBLE_VAL whenever nothing valid is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= in_data;
                        valid_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_q  <= in_data;
                        ready_q <= 1'b0;
                        state   <= ST_SKID;
                    end else if (out_xfer) begin
                        main_q  <= BUBBLE_VAL;
                        valid_q <= 1'b0;
                        state   <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE_VAL;
                        ready_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    main_q  <= BUBBLE_VAL;
                    skid_q  <= BUBBLE_VAL;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter: held valid entry not consumed and not being flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating flush counter: only flushes that actually killed a held entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (flush && (state != ST_EMPTY) && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
